// File: rtl/prn_data_spreader.sv
// PRN chip spreader: buffers generator chips, XORs them with the current nav
// symbol and releases one spread chip per programmable chip-rate tick.
module prn_data_spreader #(
  parameter int CODE_LEN       = 10230,
  parameter int EPOCHS_PER_SYM = 1,
  parameter int FIFO_DEPTH     = 16,
  parameter int DIV_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             chip_in,
  input  logic             chip_valid,
  output logic             chip_ready,
  input  logic             data_bit,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             tx_chip,
  output logic             tx_valid,
  output logic             tx_epoch,
  output logic             underrun,
  output logic             data_miss
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int EW = (EPOCHS_PER_SYM > 1) ? $clog2(EPOCHS_PER_SYM) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]       state;
  logic             mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [DIV_W-1:0] tick_cnt, div_q;
  logic [CW-1:0]    chip_cnt;
  logic [EW-1:0]    epoch_cnt;
  logic             cur_bit, next_bit, next_valid;

  logic full, empty, push, pop, tick, last_chip, last_epoch, data_hs;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign chip_ready = !full && (state != S_IDLE);
  assign data_ready = !next_valid && (state != S_IDLE);
  assign push       = chip_valid && chip_ready;
  assign tick       = (state == S_RUN) && (tick_cnt == div_q);
  assign pop        = tick && !empty;
  assign last_chip  = (chip_cnt == CW'(CODE_LEN-1));
  assign last_epoch = (epoch_cnt == EW'(EPOCHS_PER_SYM-1));
  assign data_hs    = data_valid && data_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= chip_in;
  end

  // Disable flushes on the same edge that drops the FSM to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!enable || state == S_IDLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Divider reloads its period only at a wrap, so clk_div changes are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      div_q    <= '0;
    end else if (state != S_RUN || !enable) begin
      tick_cnt <= '0;
      div_q    <= clk_div;
    end else if (tick) begin
      tick_cnt <= '0;
      div_q    <= clk_div;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      chip_cnt   <= '0;
      epoch_cnt  <= '0;
      cur_bit    <= 1'b0;
      next_bit   <= 1'b0;
      next_valid <= 1'b0;
      tx_chip    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_epoch   <= 1'b0;
      underrun   <= 1'b0;
      data_miss  <= 1'b0;
    end else begin
      tx_valid  <= 1'b0;
      tx_epoch  <= 1'b0;
      underrun  <= 1'b0;
      data_miss <= 1'b0;
      if (!enable) begin
        state      <= S_IDLE;
        chip_cnt   <= '0;
        epoch_cnt  <= '0;
        next_valid <= 1'b0;
        tx_chip    <= 1'b0;
      end else begin
        if (data_hs) begin
          next_bit   <= data_bit;
          next_valid <= 1'b1;
        end
        case (state)
          S_IDLE: state <= S_WAIT;
          S_WAIT: begin
            if (next_valid) begin
              cur_bit    <= next_bit;
              next_valid <= 1'b0;
              state      <= S_RUN;
            end
          end
          S_RUN: begin
            if (tick && empty) begin
              underrun <= 1'b1;
            end else if (pop) begin
              tx_chip  <= mem[rd_ptr] ^ cur_bit;
              tx_valid <= 1'b1;
              tx_epoch <= last_chip;
              if (!last_chip) begin
                chip_cnt <= chip_cnt + CW'(1);
              end else begin
                chip_cnt <= '0;
                if (!last_epoch) begin
                  epoch_cnt <= epoch_cnt + EW'(1);
                end else begin
                  epoch_cnt <= '0;
                  // Symbol boundary: swap in the queued symbol or stall aligned at chip 0.
                  if (next_valid) begin
                    cur_bit    <= next_bit;
                    next_valid <= 1'b0;
                  end else begin
                    data_miss <= 1'b1;
                    state     <= S_WAIT;
                  end
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prn_data_spreader.sv
// Bench for prn_data_spreader: background driver/monitor plus a transaction
// model (output i = pushed chip i XOR accepted symbol i/(CODE_LEN*EPOCHS)).
module tb_prn_data_spreader;
  localparam int CL = 8;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, use_b = 1'b0;
  logic [15:0] clk_div = '0;
  logic        chip_in = 1'b0, chip_valid = 1'b0, data_bit = 1'b0, data_valid = 1'b0;
  logic        en_a, en_b;
  logic a_cr, a_dr, a_txc, a_txv, a_txe, a_ur, a_dm;
  logic b_cr, b_dr, b_txc, b_txv, b_txe, b_ur, b_dm;
  logic m_cr, m_dr, m_txc, m_txv, m_txe, m_ur, m_dm;

  always #5 clk = ~clk;

  assign en_a = enable & ~use_b;
  assign en_b = enable & use_b;

  prn_data_spreader #(.CODE_LEN(CL), .EPOCHS_PER_SYM(1), .FIFO_DEPTH(16), .DIV_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .clk_div(clk_div),
    .chip_in(chip_in), .chip_valid(chip_valid), .chip_ready(a_cr),
    .data_bit(data_bit), .data_valid(data_valid), .data_ready(a_dr),
    .tx_chip(a_txc), .tx_valid(a_txv), .tx_epoch(a_txe), .underrun(a_ur), .data_miss(a_dm));

  prn_data_spreader #(.CODE_LEN(CL), .EPOCHS_PER_SYM(2), .FIFO_DEPTH(16), .DIV_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .clk_div(clk_div),
    .chip_in(chip_in), .chip_valid(chip_valid), .chip_ready(b_cr),
    .data_bit(data_bit), .data_valid(data_valid), .data_ready(b_dr),
    .tx_chip(b_txc), .tx_valid(b_txv), .tx_epoch(b_txe), .underrun(b_ur), .data_miss(b_dm));

  assign m_cr  = use_b ? b_cr  : a_cr;
  assign m_dr  = use_b ? b_dr  : a_dr;
  assign m_txc = use_b ? b_txc : a_txc;
  assign m_txv = use_b ? b_txv : a_txv;
  assign m_txe = use_b ? b_txe : a_txe;
  assign m_ur  = use_b ? b_ur  : a_ur;
  assign m_dm  = use_b ? b_dm  : a_dm;

  int total = 0, bad = 0, cyc = 0;
  bit src_on = 0, pat_mode = 1, c_acc = 0, d_acc = 0;
  int src_pct = 100, pidx = 0, eps = 1, n_under = 0, n_miss = 0;
  bit [7:0] pat8 = 8'b10110010;
  bit rnd_bits [256];
  bit dsend_q[$], push_q[$], sym_q[$], oc_q[$], oe_q[$];
  int ot_q[$];

  function automatic logic exp_chip(int i);
    int s = i / (CL * eps);
    if (i >= push_q.size() || s >= sym_q.size()) return 1'bx;
    return push_q[i] ^ sym_q[s];
  endfunction

  function automatic logic exp_ep(int i);
    return (i % CL) == CL - 1;
  endfunction

  task automatic run_cycles;
    forever begin @(posedge clk); cyc++; end
  endtask

  task automatic run_driver;
    forever begin
      @(posedge clk); #1;
      if (c_acc) pidx++;
      if (d_acc && dsend_q.size() > 0) void'(dsend_q.pop_front());
      chip_in    = pat_mode ? pat8[7 - (pidx % 8)] : rnd_bits[pidx % 256];
      chip_valid = src_on && ($urandom_range(99) < src_pct);
      data_valid = dsend_q.size() > 0;
      data_bit   = data_valid ? dsend_q[0] : 1'b0;
    end
  endtask

  task automatic run_monitor;
    forever begin
      @(negedge clk);
      c_acc = chip_valid && m_cr && rst_n;
      d_acc = data_valid && m_dr && rst_n;
      if (c_acc) push_q.push_back(chip_in);
      if (d_acc) sym_q.push_back(data_bit);
      if (m_txv) begin oc_q.push_back(m_txc); oe_q.push_back(m_txe); ot_q.push_back(cyc); end
      if (m_ur) n_under++;
      if (m_dm) n_miss++;
    end
  endtask

  task automatic tick_wait(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_model;
    push_q.delete(); sym_q.delete(); oc_q.delete(); oe_q.delete(); ot_q.delete(); dsend_q.delete();
    pidx = 0; n_under = 0; n_miss = 0; c_acc = 0; d_acc = 0;
  endtask

  task automatic do_reset(bit sel_b);
    src_on = 0; enable = 0; rst_n = 0; src_pct = 100;
    tick_wait(3);
    use_b = sel_b; eps = sel_b ? 2 : 1;
    clear_model();
    rst_n = 1;
    tick_wait(1);
  endtask

  task automatic wait_outs(int n, int budget);
    for (int k = 0; k < budget && oc_q.size() < n; k++) tick_wait(1);
  endtask

  task automatic load_rand;
    for (int i = 0; i < 256; i++) rnd_bits[i] = 1'($urandom);
  endtask

  task automatic test_reset;
    logic [6:0] o;
    do_reset(0);
    total++;
    if ({a_txc, a_txv, a_txe, a_ur, a_dm, a_cr, a_dr} !== 7'b0) begin
      bad++; $display("FAIL reset_idle: outs=%b want 0000000", {a_txc, a_txv, a_txe, a_ur, a_dm, a_cr, a_dr});
    end
    clk_div = 0; pat_mode = 1; src_on = 1; enable = 1;
    dsend_q.push_back(1); dsend_q.push_back(0); dsend_q.push_back(1);
    wait_outs(5, 100);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    o = {a_txc, a_txv, a_txe, a_ur, a_dm, a_cr, a_dr};
    total++;
    if (o !== 7'b0) begin bad++; $display("FAIL reset_async: outs=%b want 0000000", o); end
    enable = 0; src_on = 0;
    tick_wait(2);
    rst_n = 1;
    tick_wait(2);
    total++;
    if (a_cr !== 1'b0) begin bad++; $display("FAIL idle_chip_ready: got %b want 0", a_cr); end
    total++;
    if (a_dr !== 1'b0) begin bad++; $display("FAIL idle_data_ready: got %b want 0", a_dr); end
    clear_model();
  endtask

  task automatic test_basic;
    logic [15:0] gc, ge;
    do_reset(0);
    clk_div = 0; pat_mode = 1;
    dsend_q.push_back(1); dsend_q.push_back(0);
    src_on = 1; enable = 1;
    tick_wait(60);
    total++;
    if (oc_q.size() != 16) begin bad++; $display("FAIL basic_count: got %0d want 16", oc_q.size()); end
    gc = '0; ge = '0;
    for (int i = 0; i < 16 && i < oc_q.size(); i++) begin gc = {gc[14:0], oc_q[i]}; ge = {ge[14:0], oe_q[i]}; end
    total++;
    if (gc[15:8] !== 8'b01001101) begin bad++; $display("FAIL basic_epoch1: got %b want 01001101", gc[15:8]); end
    total++;
    if (gc[7:0] !== 8'b10110010) begin bad++; $display("FAIL basic_epoch2: got %b want 10110010", gc[7:0]); end
    total++;
    if (ge !== 16'h0101) begin bad++; $display("FAIL basic_tx_epoch: got %h want 0101", ge); end
    total++;
    if (ot_q.size() >= 16 && ot_q[15] - ot_q[0] != 15) begin
      bad++; $display("FAIL basic_rate: span %0d want 15", ot_q[15] - ot_q[0]);
    end
    total++;
    if (n_miss != 1) begin bad++; $display("FAIL basic_miss: got %0d want 1", n_miss); end
  endtask

  task automatic test_divider;
    int n0, per_bad;
    do_reset(0);
    load_rand();
    clk_div = 3; pat_mode = 0;
    for (int i = 0; i < 10; i++) dsend_q.push_back(1'($urandom));
    src_on = 1; enable = 1;
    wait_outs(1, 100);
    n0 = oc_q.size();
    tick_wait(40);
    total++;
    if (oc_q.size() - n0 != 10) begin bad++; $display("FAIL div_count: got %0d want 10", oc_q.size() - n0); end
    per_bad = 0;
    for (int i = 1; i < ot_q.size(); i++) if (ot_q[i] - ot_q[i-1] != 4) per_bad++;
    total++;
    if (per_bad != 0) begin bad++; $display("FAIL div_period: %0d gaps not 4 cycles, want 0", per_bad); end
    for (int i = 0; i < oc_q.size(); i++) begin
      total++;
      if (oc_q[i] !== exp_chip(i) || oe_q[i] !== exp_ep(i)) begin
        bad++; $display("FAIL div_stream[%0d]: got %b/%b want %b/%b", i, oc_q[i], oe_q[i], exp_chip(i), exp_ep(i));
      end
    end
  endtask

  task automatic test_underrun;
    int u0;
    do_reset(0);
    clk_div = 1; pat_mode = 1; src_on = 0;
    dsend_q.push_back(1); dsend_q.push_back(0); dsend_q.push_back(1);
    enable = 1;
    for (int k = 0; k < 50 && n_under == 0; k++) tick_wait(1);
    u0 = n_under;
    tick_wait(6);
    total++;
    if (n_under - u0 != 3) begin bad++; $display("FAIL underrun_count: got %0d want 3", n_under - u0); end
    total++;
    if (oc_q.size() != 0) begin bad++; $display("FAIL underrun_no_tx: got %0d outputs want 0", oc_q.size()); end
    src_on = 1;
    wait_outs(12, 200);
    total++;
    if (oc_q.size() < 12 || oe_q[7] !== 1'b1) begin
      bad++; $display("FAIL underrun_align: outputs=%0d ep7=%b want >=12 and 1", oc_q.size(), oe_q[7]);
    end
    for (int i = 0; i < oc_q.size(); i++) begin
      total++;
      if (oc_q[i] !== exp_chip(i) || oe_q[i] !== exp_ep(i)) begin
        bad++; $display("FAIL underrun_stream[%0d]: got %b/%b want %b/%b", i, oc_q[i], oe_q[i], exp_chip(i), exp_ep(i));
      end
    end
  endtask

  task automatic test_data_miss;
    do_reset(1);
    clk_div = 0; pat_mode = 1;
    dsend_q.push_back(1);
    src_on = 1; enable = 1;
    for (int k = 0; k < 100 && n_miss == 0; k++) tick_wait(1);
    tick_wait(30);
    total++;
    if (n_miss != 1 || oc_q.size() != 16) begin
      bad++; $display("FAIL miss_stop: miss=%0d outputs=%0d want 1 and 16", n_miss, oc_q.size());
    end
    total++;
    if (b_cr !== 1'b0 || push_q.size() != 32) begin
      bad++; $display("FAIL miss_full: ready=%b pushes=%0d want 0 and 32", b_cr, push_q.size());
    end
    dsend_q.push_back(0);
    wait_outs(32, 100);
    total++;
    if (oc_q.size() < 32 || oe_q[23] !== 1'b1) begin
      bad++; $display("FAIL miss_resume: outputs=%0d ep23=%b want >=32 and 1", oc_q.size(), oe_q[23]);
    end
    for (int i = 0; i < oc_q.size(); i++) begin
      total++;
      if (oc_q[i] !== exp_chip(i) || oe_q[i] !== exp_ep(i)) begin
        bad++; $display("FAIL miss_stream[%0d]: got %b/%b want %b/%b", i, oc_q[i], oe_q[i], exp_chip(i), exp_ep(i));
      end
    end
  endtask

  task automatic test_flush;
    do_reset(0);
    load_rand();
    clk_div = 0; pat_mode = 0; src_on = 1; enable = 1;
    tick_wait(30);
    total++;
    if (a_cr !== 1'b0 || push_q.size() != 16) begin
      bad++; $display("FAIL flush_fill: ready=%b pushes=%0d want 0 and 16", a_cr, push_q.size());
    end
    enable = 0; src_on = 0;
    tick_wait(1);
    total++;
    if (a_cr !== 1'b0 || a_dr !== 1'b0) begin
      bad++; $display("FAIL flush_idle: chip_ready=%b data_ready=%b want 0 0", a_cr, a_dr);
    end
    clear_model();
    enable = 1;
    tick_wait(20);
    total++;
    if (oc_q.size() != 0 || a_cr !== 1'b1) begin
      bad++; $display("FAIL flush_reenable: outputs=%0d ready=%b want 0 and 1", oc_q.size(), a_cr);
    end
    dsend_q.push_back(1);
    tick_wait(20);
    total++;
    if (oc_q.size() != 0 || n_under == 0) begin
      bad++; $display("FAIL flush_empty: outputs=%0d underruns=%0d want 0 and >0", oc_q.size(), n_under);
    end
  endtask

  task automatic test_random;
    do_reset(0);
    load_rand();
    pat_mode = 0; src_pct = 60; clk_div = 16'($urandom_range(2));
    for (int i = 0; i < 8; i++) dsend_q.push_back(1'($urandom));
    src_on = 1; enable = 1;
    for (int k = 0; k < 16; k++) begin
      tick_wait(25);
      clk_div = 16'($urandom_range(2));
    end
    total++;
    if (oc_q.size() != 64 || n_miss != 1) begin
      bad++; $display("FAIL rand_count: outputs=%0d miss=%0d want 64 and 1", oc_q.size(), n_miss);
    end
    for (int i = 0; i < oc_q.size(); i++) begin
      total++;
      if (oc_q[i] !== exp_chip(i) || oe_q[i] !== exp_ep(i)) begin
        bad++; $display("FAIL rand_stream[%0d]: got %b/%b want %b/%b", i, oc_q[i], oe_q[i], exp_chip(i), exp_ep(i));
      end
    end
  endtask

  initial begin
    fork
      run_cycles();
      run_driver();
      run_monitor();
    join_none
    test_reset();
    test_basic();
    test_divider();
    test_underrun();
    test_data_miss();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
